// File: rtl/execute_writeback_stage_pkg.sv
// Shared types for the execute/writeback stage: decode-state record, opcode encodings, FSM states.
package execute_writeback_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10, ALU_ADDPC = 4'd11;

    localparam logic [3:0] BR_NONE = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BLT = 4'd3,
                           BR_BGE = 4'd4, BR_BLTU = 4'd5, BR_BGEU = 4'd6, BR_JAL = 4'd7,
                           BR_JALR = 4'd8;

    localparam logic [1:0] WB_NONE = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC4 = 2'd3;
    localparam logic [1:0] MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2;

    localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM_REQ,
        ST_MEM_WAIT
    } state_t;

    // 289-bit record handed over from decode; debug fields ride along untouched.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        valid;
        logic [3:0]  alu_op;
        logic [1:0]  mem_op;
        logic [1:0]  wb_op;
        logic [3:0]  br_op;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] dbg_instr;
        logic [31:0] dbg_seq;
        logic [63:0] dbg_cycle;
        logic [1:0]  dbg_flags;
    } decode_state_t;

endpackage

// File: rtl/execute_writeback_stage_alu.sv
// Purely combinational ALU and branch-condition comparator for the execute stage.
module execute_alu
    import execute_writeback_stage_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [3:0]  br_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    output logic [31:0] result,
    output logic        br_cond
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $signed(a) >>> b[4:0];
            ALU_SLT:   result = {31'b0, lt_s};
            ALU_SLTU:  result = {31'b0, lt_u};
            ALU_PASSB: result = b;
            ALU_ADDPC: result = pc + b;
            default:   result = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_op)
            BR_BEQ:  br_cond = eq;
            BR_BNE:  br_cond = !eq;
            BR_BLT:  br_cond = lt_s;
            BR_BGE:  br_cond = !lt_s;
            BR_BLTU: br_cond = lt_u;
            BR_BGEU: br_cond = !lt_u;
            BR_JAL,
            BR_JALR: br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_writeback_stage.sv
// Execute/writeback stage: ALU and branch resolve, one data-memory access, register-file commit.
// Define EXECUTE_DEBUG_EN to add registered dbg_alu_a/dbg_alu_b/dbg_retire_pc/dbg_retire outputs.
module execute_writeback_stage
    import execute_writeback_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  decode_state_t   in_state,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
`ifdef EXECUTE_DEBUG_EN
    output logic [XLEN-1:0] dbg_alu_a,
    output logic [XLEN-1:0] dbg_alu_b,
    output logic [XLEN-1:0] dbg_retire_pc,
    output logic            dbg_retire,
`endif
    output logic            mem_err
);

    state_t        state_reg;
    decode_state_t ex_reg;
    logic [15:0]   wait_cnt_reg;

    logic [31:0] alu_b, alu_res, wb_data, target, mem_addr;
    logic [31:0] load_lane, load_ext, store_data;
    logic [3:0]  store_strb;
    logic [1:0]  lane;
    logic        br_cond, use_imm, ex_mem, ex_taken, accept;

    assign use_imm  = (ex_reg.mem_op != MEM_NONE) ||
                      (ex_reg.wb_op == WB_ALU && ex_reg.br_op == BR_NONE);
    assign alu_b    = use_imm ? ex_reg.imm : ex_reg.rs2_val;
    assign mem_addr = ex_reg.rs1_val + ex_reg.imm;
    assign lane     = mem_addr[1:0];
    assign target   = (ex_reg.br_op == BR_JALR) ? (mem_addr & ~32'd1) : (ex_reg.pc + ex_reg.imm);
    assign wb_data  = (ex_reg.wb_op == WB_PC4) ? (ex_reg.pc + 32'd4) : alu_res;

    // Records with valid=0 flow through EXEC as bubbles: no memory, no redirect.
    assign ex_mem   = ex_reg.valid && (ex_reg.mem_op != MEM_NONE);
    assign ex_taken = ex_reg.valid && br_cond;
    assign in_ready = ((state_reg == ST_IDLE) ||
                       (state_reg == ST_EXEC && !ex_mem && !ex_taken)) && !br_taken;
    assign accept   = in_valid && in_ready;

    execute_alu u_alu (
        .alu_op  (ex_reg.alu_op),
        .br_op   (ex_reg.br_op),
        .a       (ex_reg.rs1_val),
        .b       (alu_b),
        .pc      (ex_reg.pc),
        .result  (alu_res),
        .br_cond (br_cond)
    );

    always_comb begin
        load_lane = dmem_rdata >> {lane, 3'b000};
        case (ex_reg.funct3)
            F3_B:    load_ext = {{24{load_lane[7]}}, load_lane[7:0]};
            F3_H:    load_ext = {{16{load_lane[15]}}, load_lane[15:0]};
            F3_BU:   load_ext = {24'b0, load_lane[7:0]};
            F3_HU:   load_ext = {16'b0, load_lane[15:0]};
            default: load_ext = load_lane;
        endcase
    end

    always_comb begin
        case (ex_reg.funct3)
            F3_B: begin
                store_data = {4{ex_reg.rs2_val[7:0]}};
                store_strb = 4'b0001 << lane;
            end
            F3_H: begin
                store_data = {2{ex_reg.rs2_val[15:0]}};
                store_strb = 4'b0011 << lane;
            end
            default: begin
                store_data = ex_reg.rs2_val;
                store_strb = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            ex_reg         <= '0;
            wait_cnt_reg   <= '0;
            dmem_req_valid <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            br_taken       <= 1'b0;
            br_target      <= '0;
            mem_err        <= 1'b0;
        end else begin
            rf_we    <= 1'b0;
            br_taken <= 1'b0;
            mem_err  <= 1'b0;
            if (accept) begin
                ex_reg <= in_state;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (ex_mem) begin
                        state_reg      <= ST_MEM_REQ;
                        dmem_req_valid <= 1'b1;
                        dmem_we        <= (ex_reg.mem_op == MEM_STORE);
                        dmem_addr      <= {mem_addr[31:2], 2'b00};
                        dmem_wdata     <= store_data;
                        dmem_wstrb     <= (ex_reg.mem_op == MEM_STORE) ? store_strb : 4'h0;
                    end else begin
                        if (ex_reg.valid && (ex_reg.wb_op == WB_ALU || ex_reg.wb_op == WB_PC4) &&
                            ex_reg.rd != 5'd0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ex_reg.rd;
                            rf_wdata <= wb_data;
                        end
                        if (ex_taken) begin
                            br_taken  <= 1'b1;
                            br_target <= target;
                        end
                        state_reg <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                ST_MEM_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        wait_cnt_reg   <= '0;
                        state_reg      <= dmem_we ? ST_IDLE : ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_rsp_valid) begin
                        if (ex_reg.rd != 5'd0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ex_reg.rd;
                            rf_wdata <= load_ext;
                        end
                        state_reg <= ST_IDLE;
                    end else if (DMEM_TIMEOUT != 0 && wait_cnt_reg == 16'(DMEM_TIMEOUT - 1)) begin
                        mem_err   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef EXECUTE_DEBUG_EN
    // A record retires when its architectural effect is final: ALU/branch, store handshake, load data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_alu_a     <= '0;
            dbg_alu_b     <= '0;
            dbg_retire_pc <= '0;
            dbg_retire    <= 1'b0;
        end else begin
            dbg_retire <= 1'b0;
            if (state_reg == ST_EXEC) begin
                dbg_alu_a <= ex_reg.rs1_val;
                dbg_alu_b <= alu_b;
            end
            if ((state_reg == ST_EXEC && ex_reg.valid && !ex_mem) ||
                (state_reg == ST_MEM_REQ && dmem_req_ready && dmem_we) ||
                (state_reg == ST_MEM_WAIT && dmem_rsp_valid)) begin
                dbg_retire    <= 1'b1;
                dbg_retire_pc <= ex_reg.pc;
            end
        end
    end
`endif

    logic unused_fields;
    assign unused_fields = ^{ex_reg.rs1, ex_reg.rs2, ex_reg.dbg_instr, ex_reg.dbg_seq,
                             ex_reg.dbg_cycle, ex_reg.dbg_flags};

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Directed self-checking bench for execute_writeback_stage (DMEM_TIMEOUT set to 4).
module tb_execute_writeback_stage;
    import execute_writeback_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    decode_state_t in_state;
    logic          dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_wstrb;
    logic          dmem_rsp_valid;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          mem_err;

    int n_checks = 0;
    int n_errors = 0;

    decode_state_t vec [4];
    logic [31:0]   vexp[4];

    always #5 clk = ~clk;

    execute_writeback_stage #(.XLEN(32), .DMEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_state       (in_state),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .mem_err        (mem_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic decode_state_t mk(input logic [31:0] pc, input logic [31:0] rs1v,
                                         input logic [31:0] rs2v, input logic [31:0] imm,
                                         input logic [3:0] alu, input logic [1:0] mem,
                                         input logic [1:0] wb, input logic [3:0] br,
                                         input logic [2:0] f3, input logic [4:0] rd);
        decode_state_t r;
        r         = '0;
        r.valid   = 1'b1;
        r.pc      = pc;
        r.rs1_val = rs1v;
        r.rs2_val = rs2v;
        r.imm     = imm;
        r.alu_op  = alu;
        r.mem_op  = mem;
        r.wb_op   = wb;
        r.br_op   = br;
        r.funct3  = f3;
        r.rd      = rd;
        return r;
    endfunction

    // Four records back to back; each write appears two negedges after it was presented.
    task automatic run_burst(input string tag);
        for (int k = 0; k < 7; k++) begin
            step();
            if (k >= 2 && k < 6) begin
                check_val($sformatf("%s%0d_we", tag, k - 2), 32'(rf_we), 32'd1);
                check_val($sformatf("%s%0d_waddr", tag, k - 2), 32'(rf_waddr), 32'(vec[k-2].rd));
                check_val($sformatf("%s%0d_wdata", tag, k - 2), rf_wdata, vexp[k-2]);
            end else if (k == 6) begin
                check_val($sformatf("%s_we_idle", tag), 32'(rf_we), 32'd0);
            end
            check_val($sformatf("%s_ready%0d", tag, k), 32'(in_ready), 32'd1);
            if (k < 4) begin
                in_valid = 1'b1;
                in_state = vec[k];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic run_branch(input string tag, input decode_state_t rec, input logic exp_taken,
                              input logic [31:0] exp_target, input logic exp_we,
                              input logic [31:0] exp_wdata);
        step();
        in_valid = 1'b1;
        in_state = rec;
        step();
        check_val({tag, "_exec_ready"}, 32'(in_ready), 32'(!exp_taken));
        in_valid = 1'b0;
        step();
        check_val({tag, "_taken"}, 32'(br_taken), 32'(exp_taken));
        if (exp_taken) check_val({tag, "_target"}, br_target, exp_target);
        check_val({tag, "_we"}, 32'(rf_we), 32'(exp_we));
        if (exp_we) check_val({tag, "_wdata"}, rf_wdata, exp_wdata);
        check_val({tag, "_bubble_ready"}, 32'(in_ready), 32'(!exp_taken));
        step();
        check_val({tag, "_taken_clr"}, 32'(br_taken), 32'd0);
    endtask

    task automatic run_load(input string tag, input decode_state_t rec, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        step();
        in_valid       = 1'b1;
        in_state       = rec;
        dmem_req_ready = 1'b1;
        step();
        check_val({tag, "_exec_ready"}, 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        check_val({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
        check_val({tag, "_req_we"}, 32'(dmem_we), 32'd0);
        check_val({tag, "_req_addr"}, dmem_addr, exp_addr);
        step();
        check_val({tag, "_req_done"}, 32'(dmem_req_valid), 32'd0);
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
        step();
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        check_val({tag, "_we"}, 32'(rf_we), 32'd1);
        check_val({tag, "_waddr"}, 32'(rf_waddr), 32'(rec.rd));
        check_val({tag, "_wdata"}, rf_wdata, exp_wdata);
    endtask

    initial begin
        decode_state_t r;
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        in_state       = '0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = '0;

        repeat (3) step();
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_rf_we", 32'(rf_we), 32'd0);
        check_val("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check_val("rst_br_taken", 32'(br_taken), 32'd0);
        check_val("rst_mem_err", 32'(mem_err), 32'd0);
        check_val("rst_rf_wdata", rf_wdata, 32'd0);
        reset_n = 1'b1;

        // ALU operands: b = imm for wb ALU without branch, so rs2 mirrors imm here.
        vec[0] = mk(32'h0, 32'd5, 32'd7, 32'd7, ALU_ADD, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd3);
        vexp[0] = 32'd12;
        vec[1] = mk(32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1, ALU_ADD, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd4);
        vexp[1] = 32'd0;
        vec[2] = mk(32'h0, 32'h10, 32'h20, 32'h20, ALU_ADD, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd5);
        vexp[2] = 32'h30;
        vec[3] = mk(32'h0, 32'h7FFF_FFFF, 32'd1, 32'd1, ALU_ADD, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd31);
        vexp[3] = 32'h8000_0000;
        run_burst("add");

        vec[0] = mk(32'h0, 32'd100, 32'd30, 32'd30, ALU_SUB, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd5);
        vexp[0] = 32'd70;
        vec[1] = mk(32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1, ALU_SLT, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd6);
        vexp[1] = 32'd1;
        vec[2] = mk(32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1, ALU_SLTU, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd7);
        vexp[2] = 32'd0;
        vec[3] = mk(32'h0, 32'h8000_0000, 32'd4, 32'd4, ALU_SRA, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd10);
        vexp[3] = 32'hF800_0000;
        run_burst("mix");

        vec[0] = mk(32'h1000, 32'h0, 32'h10, 32'h10, ALU_ADDPC, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd11);
        vexp[0] = 32'h1010;
        vec[1] = mk(32'h0, 32'd1, 32'd31, 32'd31, ALU_SLL, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd12);
        vexp[1] = 32'h8000_0000;
        vec[2] = mk(32'h0, 32'h1234, 32'hABCD_0000, 32'hABCD_0000, ALU_PASSB, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd13);
        vexp[2] = 32'hABCD_0000;
        vec[3] = mk(32'h0, 32'hF0F0, 32'h0FF0, 32'h0FF0, ALU_XOR, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd14);
        vexp[3] = 32'hFF00;
        run_burst("misc");

        run_branch("beq", mk(32'h100, 32'd9, 32'd9, 32'h20, ALU_ADD, MEM_NONE, WB_NONE, BR_BEQ, 3'd0, 5'd0),
                   1'b1, 32'h120, 1'b0, 32'h0);
        run_branch("bne", mk(32'h100, 32'd9, 32'd9, 32'h20, ALU_ADD, MEM_NONE, WB_NONE, BR_BNE, 3'd0, 5'd0),
                   1'b0, 32'h0, 1'b0, 32'h0);
        run_branch("blt", mk(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, ALU_ADD, MEM_NONE, WB_NONE, BR_BLT, 3'd0, 5'd0),
                   1'b1, 32'h208, 1'b0, 32'h0);
        run_branch("bltu", mk(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, ALU_ADD, MEM_NONE, WB_NONE, BR_BLTU, 3'd0, 5'd0),
                   1'b0, 32'h0, 1'b0, 32'h0);
        run_branch("jal", mk(32'h200, 32'h0, 32'h0, 32'h40, ALU_ADD, MEM_NONE, WB_PC4, BR_JAL, 3'd0, 5'd0),
                   1'b1, 32'h240, 1'b0, 32'h0);
        run_branch("jalr", mk(32'h400, 32'h301, 32'h0, 32'h0, ALU_ADD, MEM_NONE, WB_PC4, BR_JALR, 3'd0, 5'd1),
                   1'b1, 32'h300, 1'b1, 32'h404);

        // A record with valid=0 is consumed without any write.
        r       = mk(32'h0, 32'd5, 32'd7, 32'd7, ALU_ADD, MEM_NONE, WB_ALU, BR_NONE, 3'd0, 5'd3);
        r.valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_state = r;
        step();
        in_valid = 1'b0;
        check_val("bubble_ready", 32'(in_ready), 32'd1);
        step();
        check_val("bubble_we", 32'(rf_we), 32'd0);

        run_load("lb", mk(32'h0, 32'h1000, 32'h0, 32'd3, ALU_ADD, MEM_LOAD, WB_MEM, BR_NONE, F3_B, 5'd8),
                 32'h8012_3456, 32'h1000, 32'hFFFF_FF80);
        run_load("lbu", mk(32'h0, 32'h1000, 32'h0, 32'd3, ALU_ADD, MEM_LOAD, WB_MEM, BR_NONE, F3_BU, 5'd8),
                 32'h8012_3456, 32'h1000, 32'h0000_0080);
        run_load("lh", mk(32'h0, 32'h1000, 32'h0, 32'd2, ALU_ADD, MEM_LOAD, WB_MEM, BR_NONE, F3_H, 5'd9),
                 32'h8012_3456, 32'h1000, 32'hFFFF_8012);

        // SH at 0x2002 held for three cycles with req_ready low.
        step();
        in_valid       = 1'b1;
        in_state       = mk(32'h0, 32'h2000, 32'hBEEF, 32'd2, ALU_ADD, MEM_STORE, WB_NONE, BR_NONE, F3_H, 5'd0);
        dmem_req_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("sh_req_valid%0d", k), 32'(dmem_req_valid), 32'd1);
            check_val($sformatf("sh_we%0d", k), 32'(dmem_we), 32'd1);
            check_val($sformatf("sh_addr%0d", k), dmem_addr, 32'h2000);
            check_val($sformatf("sh_wstrb%0d", k), 32'(dmem_wstrb), 32'hC);
            check_val($sformatf("sh_wdata%0d", k), dmem_wdata, 32'hBEEF_BEEF);
            check_val($sformatf("sh_ready%0d", k), 32'(in_ready), 32'd0);
            if (k == 2) dmem_req_ready = 1'b1;
            step();
        end
        dmem_req_ready = 1'b0;
        check_val("sh_req_done", 32'(dmem_req_valid), 32'd0);
        check_val("sh_no_we", 32'(rf_we), 32'd0);
        check_val("sh_idle_ready", 32'(in_ready), 32'd1);

        // Load never answered: four wait cycles, then a mem_err pulse.
        step();
        in_valid       = 1'b1;
        in_state       = mk(32'h0, 32'h3000, 32'h0, 32'h0, ALU_ADD, MEM_LOAD, WB_MEM, BR_NONE, F3_W, 5'd9);
        dmem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_val("to_req_valid", 32'(dmem_req_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("to_wait%0d_err", k), 32'(mem_err), 32'd0);
            check_val($sformatf("to_wait%0d_ready", k), 32'(in_ready), 32'd0);
        end
        step();
        check_val("to_mem_err", 32'(mem_err), 32'd1);
        check_val("to_no_we", 32'(rf_we), 32'd0);
        check_val("to_idle_ready", 32'(in_ready), 32'd1);
        step();
        check_val("to_err_clr", 32'(mem_err), 32'd0);
        dmem_req_ready = 1'b0;

        // Response while idle must be ignored.
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h1234_5678;
        step();
        dmem_rsp_valid = 1'b0;
        check_val("stray_rsp_we", 32'(rf_we), 32'd0);

        // Asynchronous reset while a request is pending.
        step();
        in_valid = 1'b1;
        in_state = mk(32'h0, 32'h4000, 32'h55, 32'h0, ALU_ADD, MEM_STORE, WB_NONE, BR_NONE, F3_W, 5'd0);
        step();
        in_valid = 1'b0;
        step();
        check_val("rstreq_valid", 32'(dmem_req_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_val("rstreq_drop", 32'(dmem_req_valid), 32'd0);
        step();
        check_val("rstreq_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        step();
        check_val("rstreq_stay", 32'(dmem_req_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
